// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Fetch port, data port and RAM port bundle for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        ram_en;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    // Requesters and RAM together form the master side.
    modport master (
        output if_req, if_addr,
        output mem_req, mem_rw, mem_addr, mem_wdata, mem_be,
        output ram_rdata,
        input  if_ack, if_rdata, mem_ack, mem_rdata,
        input  ram_en, ram_rw, ram_addr, ram_be, ram_wdata
    );

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_rw, mem_addr, mem_wdata, mem_be,
        input  ram_rdata,
        output if_ack, if_rdata, mem_ack, mem_rdata,
        output ram_en, ram_rw, ram_addr, ram_be, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (fetch / data) arbiter onto a single-port RAM with
//               starvation protection for the fetch port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 4
) (
    input wire           clk_i,
    input wire           rst_ni,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  starve_q, starve_d;
    logic        gnt_if_q, gnt_if_d;
    logic        rw_q, rw_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        pick_mem;
    logic        access;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            wait_q      <= 4'd0;
            starve_q    <= 4'd0;
            gnt_if_q    <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= 32'd0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            gnt_if_q    <= gnt_if_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        gnt_if_d    = gnt_if_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        // Data port wins ties unless the fetch port has waited out its quota.
        pick_mem    = bus.mem_req && !(bus.if_req && (starve_q == STARVE_LIM));

        unique case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.mem_req) begin
                    state_d = ST_ACCESS;
                    wait_d  = WAIT_INIT;
                    if (pick_mem) begin
                        gnt_if_d = 1'b0;
                        rw_d     = bus.mem_rw;
                        addr_d   = bus.mem_addr;
                        be_d     = bus.mem_be;
                        wdata_d  = bus.mem_rw ? bus.mem_wdata : 32'd0;
                        if (bus.if_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        gnt_if_d = 1'b1;
                        rw_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        be_d     = 4'hF;
                        wdata_d  = 32'd0;
                        starve_d = 4'd0;
                    end
                end
            end
            ST_ACCESS: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) begin
                    state_d = ST_RESP;
                    if (gnt_if_q) begin
                        if_rdata_d = bus.ram_rdata;
                    end else if (!rw_q) begin
                        mem_rdata_d = bus.ram_rdata & be_mask(be_q);
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign access        = (state_q == ST_ACCESS);
    assign bus.ram_en    = access;
    assign bus.ram_rw    = access & rw_q;
    assign bus.ram_addr  = access ? addr_q  : 32'd0;
    assign bus.ram_be    = access ? be_q    : 4'd0;
    assign bus.ram_wdata = access ? wdata_q : 32'd0;

    assign bus.if_ack    = (state_q == ST_RESP) &&  gnt_if_q;
    assign bus.mem_ack   = (state_q == ST_RESP) && !gnt_if_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;

endmodule
`default_nettype wire
